// File: rtl/vec_pkg.sv
// Shared definitions for the vector engines: FSM state encoding, default
// geometry and the accumulator width rule.
package vec_pkg;

  localparam int VEC_ADDR_WIDTH = 4;
  localparam int VEC_DATA_WIDTH = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH_A = 3'd1,
    ST_FETCH_B = 3'd2,
    ST_MAC     = 3'd3,
    ST_DONE    = 3'd4
  } vec_state_e;

  // Wide enough that (2^addr_w - 1) full-scale products cannot overflow.
  function automatic int acc_width(input int addr_w, input int data_w);
    return 2 * data_w + addr_w;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Registered unsigned multiply-accumulate with synchronous clear and enable.
// Clear has priority over enable.
module mac_unit
  import vec_pkg::*;
#(
  parameter int DATA_WIDTH = VEC_DATA_WIDTH,
  parameter int ACC_WIDTH  = acc_width(VEC_ADDR_WIDTH, VEC_DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc
);

  logic [2*DATA_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]    acc_d;
  logic [ACC_WIDTH-1:0]    acc_q;

  always_comb begin
    // Operands widened first so the full 2*DATA_WIDTH product is kept.
    prod  = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_WIDTH'(prod);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/vector_dot_engine.sv
// Sequences reads of two vectors from a registered-output single-port RAM and
// accumulates their unsigned dot product; start/busy/done handshake to the host.
module vector_dot_engine
  import vec_pkg::*;
#(
  parameter int ADDR_WIDTH = VEC_ADDR_WIDTH,
  parameter int DATA_WIDTH = VEC_DATA_WIDTH,
  parameter int ACC_WIDTH  = acc_width(ADDR_WIDTH, DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  input  logic [ADDR_WIDTH-1:0] length,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy,
  output logic                  done,
  output logic [ACC_WIDTH-1:0]  result
);

  localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);

  vec_state_e            state_d, state_q;
  logic [ADDR_WIDTH-1:0] base_a_d, base_a_q;
  logic [ADDR_WIDTH-1:0] base_b_d, base_b_q;
  logic [ADDR_WIDTH-1:0] len_d, len_q;
  logic [ADDR_WIDTH-1:0] idx_d, idx_q;
  logic [ADDR_WIDTH-1:0] idx_next;
  logic [DATA_WIDTH-1:0] a_reg_d, a_reg_q;
  logic [ADDR_WIDTH-1:0] ram_addr_d, ram_addr_q;
  logic                  busy_d, busy_q;
  logic                  done_d, done_q;
  logic [ACC_WIDTH-1:0]  result_d, result_q;
  logic                  mac_clr;
  logic                  mac_en;
  logic [ACC_WIDTH-1:0]  acc;

  mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (mac_clr),
    .en    (mac_en),
    .a     (a_reg_q),
    .b     (ram_rdata),
    .acc   (acc)
  );

  // ram_addr is registered and loaded on entry to each fetch state, so the
  // RAM samples it at the end of that state and data is present one state on.
  always_comb begin
    state_d    = state_q;
    base_a_d   = base_a_q;
    base_b_d   = base_b_q;
    len_d      = len_q;
    idx_d      = idx_q;
    idx_next   = idx_q + ONE_A;
    a_reg_d    = a_reg_q;
    ram_addr_d = ram_addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    mac_clr    = 1'b0;
    mac_en     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_a_d = base_a;
          base_b_d = base_b;
          len_d    = length;
          idx_d    = '0;
          mac_clr  = 1'b1;
          if (length != '0) begin
            state_d    = ST_FETCH_A;
            ram_addr_d = base_a;
            busy_d     = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_FETCH_A: begin
        ram_addr_d = base_b_q + idx_q;
        state_d    = ST_FETCH_B;
      end
      ST_FETCH_B: begin
        a_reg_d = ram_rdata;
        state_d = ST_MAC;
      end
      ST_MAC: begin
        mac_en = 1'b1;
        idx_d  = idx_next;
        if (idx_q == len_q - ONE_A) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
        end else begin
          state_d    = ST_FETCH_A;
          ram_addr_d = base_a_q + idx_next;
        end
      end
      ST_DONE: begin
        result_d = acc;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      base_a_q   <= '0;
      base_b_q   <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      a_reg_q    <= '0;
      ram_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      base_a_q   <= base_a_d;
      base_b_q   <= base_b_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      a_reg_q    <= a_reg_d;
      ram_addr_q <= ram_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
    end
  end

  assign ram_addr = ram_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;

endmodule

// File: doc/vector_dot_engine.md
Name: vector_dot_engine

Overview:
- Sequencer and multiply-accumulate stage that sits directly downstream of block_ram.
- Drives the RAM read address, consumes the RAM's registered data_out, and computes the unsigned dot product of two vectors held in the same single-port RAM (A at base_a, B at base_b).
- Reports the result with a start/busy/done handshake to the top-level controller.
- While busy, the top level routes ram_addr to the RAM and holds RAM write_enable low.

Parameters:
- ADDR_WIDTH, 4, RAM address width; also the width of length.
- DATA_WIDTH, 3, RAM word width; elements are unsigned.
- ACC_WIDTH, 2*DATA_WIDTH+ADDR_WIDTH (10), accumulator/result width. This guarantees no overflow for length up to 2^ADDR_WIDTH-1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- base_a  in  ADDR_WIDTH  RAM address of A[0].
- base_b  in  ADDR_WIDTH  RAM address of B[0].
- length  in  ADDR_WIDTH  element count, 0..2^ADDR_WIDTH-1.
- ram_addr  out  ADDR_WIDTH  read address to block_ram addr.
- ram_rdata  in  DATA_WIDTH  block_ram data_out; valid one cycle after ram_addr.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when result is valid.
- result  out  ACC_WIDTH  dot product; held until the next accepted start.

Behaviour:
- Reset (async, immediate): state=IDLE; ram_addr=0, busy=0, done=0, result=0; internal idx, a_reg and acc cleared.
  - Reset during any state aborts the operation and does not pulse done.
- On the start edge in IDLE, latch base_a, base_b and length. Set idx=0 and acc=0. Later input changes are ignored until the next IDLE.
- FSM states:
  - IDLE: busy=0. start=1 and length!=0 -> FETCH_A. start=1 and length==0 -> DONE. start=0 -> stay.
  - FETCH_A: ram_addr=base_a+idx -> FETCH_B.
  - FETCH_B: ram_addr=base_b+idx; a_reg<=ram_rdata (A[idx]) -> MAC.
  - MAC: acc<=acc+a_reg*ram_rdata (B[idx]); idx<=idx+1. If idx==length-1 -> DONE, else -> FETCH_A.
  - DONE: result<=acc (0 when length==0); done=1 for this cycle only; busy=0 -> IDLE.
- Latency: start accepted at edge k -> done high in the cycle following edge k+3*length+1.
  - length=0 gives done in the cycle after edge k+1.
  - Back-to-back: start may be accepted again on the edge that leaves DONE's following IDLE cycle. Minimum period is 3*length+2 cycles.
- Address arithmetic is modulo 2^ADDR_WIDTH; base+idx wraps, e.g. base 14 reads 14,15,0,1. Overlapping A/B regions are legal.
- Products are DATA_WIDTH x DATA_WIDTH unsigned -> 2*DATA_WIDTH bits, zero-extended to ACC_WIDTH before the add.
- start while busy or in DONE is ignored and not queued.
- ram_addr holds its last value in IDLE and DONE.
- busy=1 in FETCH_A, FETCH_B and MAC only.
- result changes only in DONE and on reset.

Decomposition:
- Shared package vec_pkg:
  - FSM state encoding (IDLE, FETCH_A, FETCH_B, MAC, DONE; 3 bits).
  - The ACC_WIDTH derivation function, reused by later engines.
- One natural sub-module: mac_unit.
  - Registered multiply-accumulate with clear and enable.
  - Inputs: a, b, clr, en. Output: acc.
- FSM, address generation and handshake stay in vector_dot_engine.

Test Plan:
- Bench setup for all cases: real block_ram (4/3 parameters); RAM preloaded through its write port; write_enable held low during the run.
- Basic: RAM[0..3]=6,2,4,1, RAM[8..11]=3,7,5,2; start with base_a=0, base_b=8, length=4.
  - Expect ram_addr sequence 0,8,1,9,2,10,3,11.
  - Expect done exactly 13 cycles after start, result=54, busy high for 12 cycles.
- Zero length: length=0 -> done the cycle after acceptance, result=0, ram_addr unchanged.
- Wrap and max: RAM[14]=RAM[15]=RAM[0]=RAM[1]=7, base_a=base_b=14, length=4 -> addresses 14,14,15,15,0,0,1,1; result=196.
  - Separate run with all words 7, length=15 -> result=735, no overflow.
- Start while busy: pulse start again mid-run with different bases -> ignored. Result=54, exactly one done pulse. A new start after DONE is accepted.
- Reset mid-op: assert reset during the second MAC, between clock edges.
  - Outputs clear immediately: busy=0, done=0, result=0, ram_addr=0.
  - No done pulse follows. A fresh start then yields 54.
